// File: rtl/fht_frame_sched_if.sv
// Frame scheduler bus: source requests/samples, bank-RAM load/read ports,
// FHT core handshake and status.
interface fht_frame_sched_if #(
  parameter int unsigned A_BIT = 8,
  parameter int unsigned D_BIT = 16
);
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             valid;
  logic [D_BIT-1:0] data;
  logic             load_we;
  logic [1:0]       load_bank;
  logic [A_BIT-1:0] load_addr;
  logic [D_BIT-1:0] load_data;
  logic             start;
  logic             core_rdy;
  logic             rd_en;
  logic [1:0]       rd_bank;
  logic [A_BIT-1:0] rd_addr;
  logic             out_valid;
  logic             out_ch;
  logic             busy;
  logic             done;
  logic             err;

  // Scheduler side.
  modport master (
    input  req, valid, data, core_rdy,
    output gnt, load_we, load_bank, load_addr, load_data, start,
           rd_en, rd_bank, rd_addr, out_valid, out_ch, busy, done, err
  );

  // Sources, core and bank RAM side.
  modport slave (
    output req, valid, data, core_rdy,
    input  gnt, load_we, load_bank, load_addr, load_data, start,
           rd_en, rd_bank, rd_addr, out_valid, out_ch, busy, done, err
  );
endinterface

// File: rtl/fht_frame_sched.sv
// fht_frame_sched: shares one FHT core and its four-bank RAM between two
// sources. Round-robin grant, sample load, core start, wait, read-back.
// Optional watchdog on the core wait: define FHT_SCHED_TIMEOUT_EN.
module fht_frame_sched #(
  parameter int unsigned A_BIT   = 8,
  parameter int unsigned D_BIT   = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 6000
) (
  input  logic               clk,
  input  logic               rst,
  fht_frame_sched_if.master  bus
);

  localparam int unsigned N   = 4 * (2 ** A_BIT);
  localparam int unsigned K_W = A_BIT + 2;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_BUSY, RUN, UNLOAD, DRAIN
  } state_t;

  state_t            state;
  logic              last;
  logic              pick;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    j;
  logic [K_W-1:0]    jn;
  logic [RD_LAT-1:0] vpipe;

`ifdef FHT_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
`else
  // TIMEOUT only matters when the watchdog is compiled in.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // Round-robin pick: on a tie the source not granted last wins.
  always_comb begin
    pick = bus.req[1];
    if (bus.req == 2'b11) pick = ~last;
    jn = j + K_W'(1);
  end

  // Frame transaction FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 1'b1;
      k             <= '0;
      j             <= '0;
      bus.gnt       <= '0;
      bus.out_ch    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.load_we   <= 1'b0;
      bus.load_bank <= '0;
      bus.load_addr <= '0;
      bus.load_data <= '0;
      bus.start     <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_bank   <= '0;
      bus.rd_addr   <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
`ifdef FHT_SCHED_TIMEOUT_EN
      wd            <= '0;
`endif
    end else begin
      bus.load_we <= 1'b0;
      bus.start   <= 1'b0;
      bus.done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.core_rdy && bus.req != 2'b00) begin
            bus.gnt    <= pick ? 2'b10 : 2'b01;
            bus.busy   <= 1'b1;
            bus.out_ch <= pick;
            bus.err    <= 1'b0;
            last       <= pick;
            k          <= '0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (bus.valid) begin
            bus.load_we   <= 1'b1;
            bus.load_bank <= k[1:0];
            bus.load_addr <= k[K_W-1:2];
            bus.load_data <= bus.data;
            k             <= k + K_W'(1);
            if (k == K_W'(N - 1)) state <= START;
          end
        end
        START: begin
          bus.start <= 1'b1;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.core_rdy) state <= RUN;
        end
        RUN: begin
          if (bus.core_rdy) begin
            bus.rd_en   <= 1'b1;
            bus.rd_bank <= '0;
            bus.rd_addr <= '0;
            j           <= '0;
            state       <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (j == K_W'(N - 1)) begin
            bus.rd_en <= 1'b0;
            j         <= '0;
            state     <= DRAIN;
          end else begin
            bus.rd_en   <= 1'b1;
            bus.rd_bank <= jn[1:0];
            bus.rd_addr <= jn[K_W-1:2];
            j           <= jn;
          end
        end
        DRAIN: begin
          // Last read data appears RD_LAT cycles after the last read.
          if (j == K_W'(RD_LAT - 1)) begin
            bus.done <= 1'b1;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            j        <= '0;
            state    <= IDLE;
          end else begin
            j <= jn;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef FHT_SCHED_TIMEOUT_EN
      // Watchdog over the core wait; overrides the case above when it fires.
      if (state == WAIT_BUSY || state == RUN) begin
        wd <= wd + WD_W'(1);
        if (wd == WD_W'(TIMEOUT - 1)) begin
          bus.err   <= 1'b1;
          bus.gnt   <= '0;
          bus.busy  <= 1'b0;
          bus.rd_en <= 1'b0;
          wd        <= '0;
          state     <= IDLE;
        end
      end else begin
        wd <= '0;
      end
`endif
    end
  end

  // Read-valid delay line matching the bank RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= bus.rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  assign bus.out_valid = vpipe[RD_LAT-1];

endmodule

// File: tb/tb_fht_frame_sched.sv
// Directed bench for fht_frame_sched with load/read scoreboards.
module tb_fht_frame_sched;

  localparam int unsigned A_BIT  = 8;
  localparam int unsigned D_BIT  = 16;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned N      = 4 * (2 ** A_BIT);

  typedef struct packed {
    logic [1:0]       bank;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] data;
  } ld_t;

  typedef struct packed {
    logic [1:0]       bank;
    logic [A_BIT-1:0] addr;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fht_frame_sched_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_frame_sched #(
    .A_BIT(A_BIT), .D_BIT(D_BIT), .RD_LAT(RD_LAT), .TIMEOUT(6000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ld_t load_q[$];
  rd_t rd_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  m_assert = 0;
  int  m_fail   = 0;
  int  rd_cnt   = 0;
  int  ov_cnt   = 0;
  int  start_cnt = 0;
  logic [1:0] hist = '0;
  logic prev_we = 1'b0;
  logic prev_ov = 1'b0;
  ld_t  le;
  rd_t  re;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mcheck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    m_assert++;
    assert (obs === exp) else begin
      m_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops scoreboards, checks read-valid lag and pulse placement.
  always @(negedge clk) begin
    if (rst) begin
      hist    = '0;
      prev_we = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (bus.load_we) begin
        if (load_q.size() == 0) begin
          mcheck("load_we_unexpected", 64'(bus.load_we), 64'd0);
        end else begin
          le = load_q.pop_front();
          mcheck("load_bank", 64'(bus.load_bank), 64'(le.bank));
          mcheck("load_addr", 64'(bus.load_addr), 64'(le.addr));
          mcheck("load_data", 64'(bus.load_data), 64'(le.data));
        end
      end
      if (bus.start) begin
        start_cnt++;
        mcheck("start_after_last_we", 64'(prev_we), 64'd1);
        mcheck("start_load_q_empty", 64'(load_q.size()), 64'd0);
      end
      if (bus.rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          mcheck("rd_en_unexpected", 64'(bus.rd_en), 64'd0);
        end else begin
          re = rd_q.pop_front();
          mcheck("rd_bank", 64'(bus.rd_bank), 64'(re.bank));
          mcheck("rd_addr", 64'(bus.rd_addr), 64'(re.addr));
        end
      end
      mcheck("out_valid_lag", 64'(bus.out_valid), 64'(hist[1]));
      if (bus.out_valid) ov_cnt++;
      if (bus.done) begin
        mcheck("done_after_last_valid", 64'(prev_ov), 64'd1);
        mcheck("done_out_valid_low", 64'(bus.out_valid), 64'd0);
      end
      hist    = {hist[0], bus.rd_en};
      prev_we = bus.load_we;
      prev_ov = bus.out_valid;
    end
  end

  task automatic wait_grant(input logic [1:0] eg);
    int waited;
    waited = 0;
    while (bus.gnt == 2'b00 && waited < 20) begin
      step();
      waited++;
    end
    check("gnt", 64'(bus.gnt), 64'(eg));
    check("grant_latency", 64'(waited), 64'd1);
    check("busy_at_grant", 64'(bus.busy), 64'd1);
    check("out_ch", 64'(bus.out_ch), 64'(eg[1]));
    check("err_at_grant", 64'(bus.err), 64'd0);
  endtask

  task automatic run_frame(input logic [1:0] eg, input bit ramp, input bit gap,
                           input int core_time, input bit stray, input bit drop,
                           input bit rst_mid);
    int waited;
    int rd0, ov0, st0;
    logic [A_BIT+1:0] kk;
    ld_t e;
    rd_t r;
    wait_grant(eg);
    rd0 = rd_cnt;
    ov0 = ov_cnt;
    st0 = start_cnt;
    for (int k = 0; k < int'(N); k++) begin
      if (gap) begin
        bus.valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      kk = k[A_BIT+1:0];
      bus.valid = 1'b1;
      bus.data  = ramp ? D_BIT'(k) : D_BIT'($urandom);
      e.bank = kk[1:0];
      e.addr = kk[A_BIT+1:2];
      e.data = bus.data;
      load_q.push_back(e);
      if (drop && k == int'(N / 2)) bus.req[0] = 1'b0;
      step();
    end
    bus.valid = 1'b0;
    waited = 0;
    while (!bus.start && waited < 10) begin
      step();
      waited++;
    end
    check("start_seen", 64'(bus.start), 64'd1);
    check("start_latency", 64'(waited), 64'd1);
    repeat (2) step();
    bus.core_rdy = 1'b0;
    if (stray) begin
      repeat (3) step();
      bus.valid = 1'b1;
      bus.data  = 16'hdead;
      step();
      bus.valid = 1'b0;
    end
    repeat (core_time) step();
    check("no_rd_in_run", 64'(bus.rd_en), 64'd0);
    check("busy_in_run", 64'(bus.busy), 64'd1);
    for (int jx = 0; jx < int'(N); jx++) begin
      kk = jx[A_BIT+1:0];
      r.bank = kk[1:0];
      r.addr = kk[A_BIT+1:2];
      rd_q.push_back(r);
    end
    bus.core_rdy = 1'b1;
    step();
    check("rd_en_first", 64'(bus.rd_en), 64'd1);
    if (rst_mid) begin
      repeat (100) step();
      rst = 1'b1;
      #1;
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_rd_en", 64'(bus.rd_en), 64'd0);
      check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_ch", 64'(bus.out_ch), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      rd_q.delete();
      repeat (2) step();
      bus.req = 2'b11;
      rst = 1'b0;
    end else begin
      waited = 0;
      while (!bus.done && waited < int'(N + RD_LAT + 20)) begin
        step();
        waited++;
      end
      check("done_seen", 64'(bus.done), 64'd1);
      check("done_latency", 64'(waited), 64'(N + RD_LAT));
      check("gnt_clear_at_done", 64'(bus.gnt), 64'd0);
      check("busy_clear_at_done", 64'(bus.busy), 64'd0);
      check("rd_en_count", 64'(rd_cnt - rd0), 64'(N));
      check("out_valid_count", 64'(ov_cnt - ov0), 64'(N));
      check("start_count", 64'(start_cnt - st0), 64'd1);
      check("rd_q_empty", 64'(rd_q.size()), 64'd0);
      check("load_q_empty", 64'(load_q.size()), 64'd0);
    end
  endtask

  initial begin
    bus.req      = 2'b00;
    bus.valid    = 1'b0;
    bus.data     = '0;
    bus.core_rdy = 1'b1;
    repeat (3) step();
    check("reset_gnt", 64'(bus.gnt), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_load_we", 64'(bus.load_we), 64'd0);
    check("reset_start", 64'(bus.start), 64'd0);
    check("reset_rd_en", 64'(bus.rd_en), 64'd0);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_err", 64'(bus.err), 64'd0);
    check("reset_out_ch", 64'(bus.out_ch), 64'd0);
    rst = 1'b0;
    step();
    check("idle_no_req_gnt", 64'(bus.gnt), 64'd0);

    // Both request: source 0 first, long core run, ramp data.
    bus.req = 2'b11;
    run_frame(2'b01, 1'b1, 1'b0, 5200, 1'b0, 1'b0, 1'b0);
    // Still both requesting: source 1, gapped samples, stray iVALID in RUN.
    run_frame(2'b10, 1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b0);
    // Source 0 again; it drops its request mid-load.
    run_frame(2'b01, 1'b0, 1'b0, 30, 1'b1, 1'b1, 1'b0);
    bus.req = 2'b11;
    // Source 1, reset in the middle of the read-back.
    run_frame(2'b10, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b1);
    // After reset the tie goes to source 0.
    wait_grant(2'b01);

    n_assert = n_assert + m_assert;
    n_fail   = n_fail + m_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fht_frame_sched.md
# fht_frame_sched

Frame scheduler that shares one FHT core and its four-bank working RAM between two sample sources. It arbitrates frame requests round-robin, streams the granted source's samples into the banks, and pulses the core start. It then waits for the core to finish, reads the transformed frame back out in sample order, and releases the grant. It sits between the input channel buffers and the FHT core/bank-RAM datapath.

## Interface
- A_BIT, 8, bank RAM address width; frame length N = 4·2^A_BIT (1024 by default)
- D_BIT, 16, sample width
- RD_LAT, 1, bank RAM read latency in cycles (1..3)
- TIMEOUT, 6000, max cycles allowed in WAIT_BUSY+RUN (used only with watchdog)

Ports:
- iCLK  in  1  clock, all logic on rising edge
- iRESET  in  1  asynchronous, active-high reset
- iREQ  in  2  per-source frame request, level; held by the source until its grant
- oGNT  out  2  one-hot grant, held for the whole frame transaction
- iVALID  in  1  sample strobe from the granted source
- iDATA  in  D_BIT  sample
- oLOAD_WE  out  1  bank write enable
- oLOAD_BANK  out  2  target bank
- oLOAD_ADDR  out  A_BIT  target address
- oLOAD_DATA  out  D_BIT  registered iDATA
- oSTART  out  1  one-cycle start pulse to FHT core
- iCORE_RDY  in  1  core idle flag (high when idle)
- oRD_EN  out  1  bank read enable
- oRD_BANK  out  2  read bank
- oRD_ADDR  out  A_BIT  read address
- oOUT_VALID  out  1  oRD_EN delayed RD_LAT cycles; bank data is valid
- oOUT_CH  out  1  source index of the frame being output
- oBUSY  out  1  state != IDLE
- oDONE  out  1  one-cycle frame-complete pulse
- oERR  out  1  sticky watchdog error

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, RUN, UNLOAD, DRAIN.
- IDLE: when iCORE_RDY=1 and iREQ≠0, grant and go to LOAD. Arbitration is round-robin: a source that was not granted last wins ties. The last-grant register resets to 1, so source 0 wins the first tie.
- LOAD: a 10-bit (A_BIT+2) sample counter k counts accepted iVALID pulses. Sample k goes to bank k[1:0], address k[A_BIT+1:2]. After sample N−1 is accepted, go to START. iVALID outside LOAD is ignored.
- START: oSTART=1 for exactly this cycle, then WAIT_BUSY.
- WAIT_BUSY: stay until iCORE_RDY=0, then go to RUN.
- RUN: stay until iCORE_RDY=1, then go to UNLOAD.
- UNLOAD: oRD_EN=1 for N consecutive cycles. The read index j maps to bank j[1:0], address j[A_BIT+1:2]. No backpressure. After the last read, go to DRAIN.
- DRAIN: wait until the last oOUT_VALID has occurred. In the next cycle, pulse oDONE, clear oGNT, and return to IDLE.
- A source dropping iREQ after grant does not abort the frame; the grant is held to completion.
- oOUT_CH is set at grant and held until the next grant.
- Reset at any point returns all state to IDLE and clears every output.

## Timing
- Reset values: all outputs 0; last-grant = 1; counters 0.
- Request seen in IDLE at edge t: oGNT and oBUSY are high from t+1.
- iVALID/iDATA sampled at edge t: oLOAD_WE/BANK/ADDR/DATA are valid in cycle t+1 (one register stage).
- oSTART is high in the cycle immediately after the final oLOAD_WE.
- oRD_EN starts in the cycle after iCORE_RDY is sampled high in RUN.
- oOUT_VALID = oRD_EN delayed exactly RD_LAT cycles.
- oDONE fires 1 cycle after the last oOUT_VALID. oGNT and oBUSY drop at the same edge.
- Earliest next grant is 1 cycle after oDONE.
- Minimum frame time with back-to-back iVALID: N+1 (load) + 1 (start) + core time + N + RD_LAT + 1.

## Configuration
- FHT_SCHED_TIMEOUT_EN defined: a cycle counter runs in WAIT_BUSY and RUN.
  - On reaching TIMEOUT, set oERR, clear oGNT, go to IDLE, and do not pulse oDONE.
  - oERR stays set until the next grant, which clears it.
- FHT_SCHED_TIMEOUT_EN undefined: no counter; oERR is tied to 0; WAIT_BUSY and RUN wait indefinitely.

## Test plan
- Reset, then iREQ=2'b11 with iCORE_RDY=1 -> oGNT=2'b01 next cycle. After that frame's oDONE, with both still requesting -> oGNT=2'b10.
- 1024 back-to-back iVALID with iDATA=k -> 1024 writes; sample 5 goes to bank 1, address 1; sample 1023 goes to bank 3, address 255; oSTART pulses once, the cycle after the last write.
- Core model drops iCORE_RDY 2 cycles after oSTART and raises it 5200 cycles later, with RD_LAT=2 -> exactly 1024 oRD_EN cycles, exactly 1024 oOUT_VALID cycles lagging by 2, and oDONE one cycle after the last valid.
- iREQ[0] deasserted mid-LOAD, and iVALID pulsed while in RUN -> frame completes normally; the stray iVALID produces no oLOAD_WE.
- iRESET asserted mid-UNLOAD -> all outputs 0 immediately. After release, iREQ=2'b11 grants source 0.
- With FHT_SCHED_TIMEOUT_EN and TIMEOUT=100, iCORE_RDY held low -> oERR=1 and oGNT=0 after 100 cycles with no oDONE. oERR clears on the next grant.
